// File: rtl/core_bus_sram_if.sv
// Word-addressed core bus: initiator drives request fields, responder returns
// a one-cycle ready pulse with read data.
interface core_bus_sram_if;
    logic [29:0] bus_addr;
    logic        bus_start;
    logic        bus_write;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_data_be;
    logic        bus_ready;
    logic [31:0] bus_data_rd;

    modport master (
        output bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be,
        input  bus_ready, bus_data_rd
    );

    modport slave (
        input  bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be,
        output bus_ready, bus_data_rd
    );
endinterface

// File: rtl/core_bus_sram.sv
// Bus responder backed by a byte-writable word array, with a configurable
// number of wait states between request acceptance and bus_ready.
module core_bus_sram #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    core_bus_sram_if.slave  bus,
    output logic            busy
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0]          mem [DEPTH];
    state_t               state, state_next;
    logic [3:0]           count, count_next;
    logic                 accept, access;
    logic [ADDR_BITS-1:0] lat_addr, acc_addr;
    logic                 lat_write, acc_write;
    logic [31:0]          lat_wdata, acc_wdata;
    logic [3:0]           lat_be, acc_be;
    logic [31:0]          data_rd;
    logic                 unused_addr_bits;

    // Upper address bits are deliberately ignored so addresses alias.
    assign unused_addr_bits = ^bus.bus_addr[29:ADDR_BITS];

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        access     = 1'b0;
        acc_addr   = lat_addr;
        acc_write  = lat_write;
        acc_wdata  = lat_wdata;
        acc_be     = lat_be;
        case (state)
            S_IDLE, S_RESP: begin
                if (bus.bus_start) begin
                    accept = 1'b1;
                    if (WS == 4'd0) begin
                        // Zero wait states: access straight from the bus inputs.
                        access     = 1'b1;
                        acc_addr   = bus.bus_addr[ADDR_BITS-1:0];
                        acc_write  = bus.bus_write;
                        acc_wdata  = bus.bus_data_wr;
                        acc_be     = bus.bus_data_be;
                        state_next = S_RESP;
                    end else begin
                        count_next = WS;
                        state_next = S_WAIT;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    access     = 1'b1;
                    state_next = S_RESP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_be    <= '0;
            data_rd   <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                lat_addr  <= bus.bus_addr[ADDR_BITS-1:0];
                lat_write <= bus.bus_write;
                lat_wdata <= bus.bus_data_wr;
                lat_be    <= bus.bus_data_be;
            end
            if (access && !acc_write) begin
                data_rd <= mem[acc_addr];
            end
        end
    end

    // Array is never reset; rst_n only blocks writes while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && access && acc_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.bus_ready   = (state == S_RESP);
    assign bus.bus_data_rd = data_rd;
    assign busy            = (state != S_IDLE);
endmodule
